vga_sync_ctrl: RTL

VGA timing master for the 640x480@60 display path, running on the pixel clock. It generates the raster counters and the active-video qualifier (h_cnt, v_cnt, valid) consumed by pixel generators such as the flying-logo block. It takes their 24-bit vga_data back and drives the DAC/connector pins, delaying sync and blank to match the generator's pipeline latency. It forces RGB to black outside the active area, whatever the generator returns.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_sync_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing defaults, sync bundle type and RGB field slices
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam int SYNC_W = $bits(sync_t);

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth shift register with synchronous clear to a constant
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ resetn;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!resetn) stage_q[i] <= CLR_VAL;
        else         stage_q[i] <= stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - VGA raster counters, pipeline-aligned sync/blank and black-forced RGB out
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             valid,
  output logic             frame_start,
  input  logic [23:0]      vga_data,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0};

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             valid_q, valid_d;
  logic             frame_start_q, frame_start_d;

  // valid/frame_start look at the next counts so they line up with h_cnt/v_cnt
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
    valid_d       = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign valid       = valid_q;
  assign frame_start = frame_start_q;

  sync_t sync_raw;
  sync_t sync_dly;

  always_comb begin
    sync_raw.hs = in_window(h_cnt_q, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    sync_raw.vs = in_window(v_cnt_q, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    sync_raw.de = valid_q;
  end

  vga_delay_line #(
    .DEPTH   (PIPE_DLY),
    .WIDTH   (SYNC_W),
    .CLR_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk    (pclk),
    .resetn (rst),
    .din    (sync_raw),
    .dout   (sync_dly)
  );

  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;

  // generators return white in blanking, so RGB is gated by the delayed de
  always_comb begin
    rgb_d     = sync_dly.de ? vga_data : 24'h0;
    hs_d      = sync_dly.hs;
    vs_d      = sync_dly.vs;
    blank_n_d = sync_dly.de;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      rgb_q     <= 24'h0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign vga_r       = rgb_q[R_MSB:R_LSB];
  assign vga_g       = rgb_q[G_MSB:G_LSB];
  assign vga_b       = rgb_q[B_MSB:B_LSB];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;

endmodule
